// File: rtl/dm_wbuf_ctrl.sv
// dm_wbuf_ctrl: data-memory responder for the MEM stage.
// A slow single-port word array (LAT cycles per access) is fronted by a
// posted write buffer with store-to-load forwarding from the youngest match.
// Optional macro DM_PERF_EN adds the stall_cnt / fwd_cnt performance counters.
module dm_wbuf_ctrl #(
  parameter int AW       = 10,
  parameter int LAT      = 2,
  parameter int WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wrt_data,
  output logic [15:0] rd_data,
  output logic        stall,
  output logic        wb_empty
`ifdef DM_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] fwd_cnt
`endif
);

  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int NW = $clog2(WB_DEPTH + 1);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, RD_WAIT, RD_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [NW-1:0]   count_q, count_d;
  logic [15:0]     rd_q;

  logic [AW-1:0]   wb_addr_q [WB_DEPTH];
  logic [15:0]     wb_data_q [WB_DEPTH];
  logic [15:0]     mem [2**AW];

  logic [AW-1:0]   addr_w;
  logic            is_load, full, hit, miss, push, pop, rd_en;
  logic [15:0]     fwd_data;
  logic [WB_DEPTH-1:0] slot_hit;
  logic [PW-1:0]   slot_age [WB_DEPTH];

  assign addr_w  = addr[AW-1:0];
  assign is_load = re & ~we;
  assign full    = (count_q == NW'(WB_DEPTH));
  assign wb_empty = (count_q == '0);

  // Upper address bits are deliberately ignored.
  generate
    if (AW < 16) begin : g_addr_unused
      logic addr_hi_unused;
      assign addr_hi_unused = ^addr[15:AW];
    end
  endgenerate

  // Per-slot match: slot is live when its age (distance from head) is below count.
  generate
    for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_slot
      assign slot_age[gi] = PW'(gi) - head_q;
      assign slot_hit[gi] = ((NW'(slot_age[gi]) < count_q) && (wb_addr_q[gi] == addr_w));
    end
  endgenerate

  // Walk from oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin : walk
      logic [PW-1:0] idx;
      idx = head_q + PW'(i);
      if (slot_hit[idx]) begin
        hit      = 1'b1;
        fwd_data = wb_data_q[idx];
      end
    end
  end

  assign miss  = is_load & ~hit;
  // A full buffer blocks the store even if the head pops this cycle.
  assign push  = we & ~full;
  assign pop   = (state_q == DRAIN) && (cnt_q == '0);
  assign rd_en = (state_q == RD_WAIT) && (cnt_q == '0);
  assign stall = (miss & (state_q != RD_DONE)) | (we & full);

  // Load data mux: a combined re&we is a store and returns zero.
  always_comb begin
    rd_data = '0;
    if (!we) begin
      if (state_q == RD_DONE) rd_data = rd_q;
      else if (re && hit)     rd_data = fwd_data;
    end
  end

  // Next-state logic: a pending miss in IDLE outranks draining.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = RD_WAIT;
          cnt_d   = CW'(LAT - 1);
        end else if (!wb_empty) begin
          state_d = DRAIN;
          cnt_d   = CW'(LAT - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer pointer and occupancy bookkeeping.
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Read-data register captures the array word at the end of the read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_q <= '0;
    else if (rd_en) rd_q <= mem[addr_w];
  end

  // Write-buffer payload storage; liveness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[tail_q] <= addr_w;
      wb_data_q[tail_q] <= wrt_data;
    end
  end

  // Array write port: the buffer head retires at the end of a drain.
  always_ff @(posedge clk) begin
    if (pop) mem[wb_addr_q[head_q]] <= wb_data_q[head_q];
  end

`ifdef DM_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF)          stall_cnt_d = stall_cnt_q + 1'b1;
    if (is_load && hit && fwd_cnt_q != 16'hFFFF)   fwd_cnt_d   = fwd_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_dm_wbuf_ctrl.sv
// Testbench for dm_wbuf_ctrl: cycle-exact vector table, hand-written reset
// sequence, and randomized traffic checked against a shadow-memory model.
module tb_dm_wbuf_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wrt_data, rd_data;
  logic        re, we, stall, wb_empty;

  int checks   = 0;
  int failures = 0;

  dm_wbuf_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .re       (re),
    .we       (we),
    .wrt_data (wrt_data),
    .rd_data  (rd_data),
    .stall    (stall),
    .wb_empty (wb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        exp_stall;
    logic [15:0] exp_rd;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[$];

  // Architectural view: every load returns the latest accepted store.
  logic [15:0] shadow  [1024];
  bit          written [1024];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void v(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic st,
                            input logic [15:0] rd, input logic emp);
    vec_t x;
    x.re = r; x.we = w; x.addr = a; x.data = d;
    x.exp_stall = st; x.exp_rd = rd; x.exp_empty = emp;
    vecs.push_back(x);
  endfunction

  // One request, held until stall drops, checked against the shadow memory.
  task automatic xact(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    bit done;
    int waited;
    done = 0;
    waited = 0;
    re = r; we = w; addr = a; wrt_data = d;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        if (w) begin
          if (r) chk("rewe_rd_zero", rd_data, 16'h0000);
          shadow[a[9:0]]  = d;
          written[a[9:0]] = 1'b1;
          $display("xact store addr=%h data=%h wait=%0d", a, d, waited);
        end else if (r) begin
          chk("load_data", rd_data, shadow[a[9:0]]);
          $display("xact load  addr=%h data=%h wait=%0d", a, rd_data, waited);
        end
        done = 1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL xact_timeout: stall still %b after 20 cycles, required 0 (addr=%h)", stall, a);
    end
    re = 0; we = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; re = 0; we = 0; addr = '0; wrt_data = '0;

    // Cycle-exact table (LAT=2, WB_DEPTH=2), starting right after reset.
    //   re we  addr      data      stall rd        empty
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1); // reset state
    v(0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 1); // store BEEF
    v(1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0); // forward next cycle
    v(1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0); // forward while draining
    v(1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 0); // forward from head in pop cycle
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    v(0, 1, 16'h0010, 16'hAAAA, 0, 16'h0000, 1); // older store
    v(0, 1, 16'h0010, 16'hBBBB, 0, 16'h0000, 0); // younger store, same address
    v(1, 0, 16'h0410, 16'h0000, 0, 16'hBBBB, 0); // youngest wins, upper bits ignored
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    v(1, 1, 16'h0005, 16'h7777, 0, 16'h0000, 1); // re&we acts as a store
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    v(1, 0, 16'hFC05, 16'h0000, 1, 16'h0000, 1); // miss load of 0x0005
    v(1, 0, 16'hFC05, 16'h0000, 1, 16'h0000, 1);
    v(1, 0, 16'hFC05, 16'h0000, 1, 16'h0000, 1);
    v(1, 0, 16'hFC05, 16'h0000, 0, 16'h7777, 1); // data after LAT+1 stall cycles
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    v(0, 1, 16'h0020, 16'h1234, 0, 16'h0000, 1); // preload 0x0020
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(1, 0, 16'h0020, 16'h0000, 1, 16'h0000, 1); // miss cycle 0
    v(1, 0, 16'h0020, 16'h0000, 1, 16'h0000, 1); // cycle 1
    v(1, 0, 16'h0020, 16'h0000, 1, 16'h0000, 1); // cycle 2
    v(1, 0, 16'h0020, 16'h0000, 0, 16'h1234, 1); // cycle 3
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
    v(0, 1, 16'h0030, 16'h1111, 0, 16'h0000, 1); // W1
    v(0, 1, 16'h0031, 16'h2222, 0, 16'h0000, 0); // W2 fills buffer
    v(0, 1, 16'h0032, 16'h3333, 1, 16'h0000, 0); // W3 blocked
    v(0, 1, 16'h0032, 16'h3333, 1, 16'h0000, 0); // pop cycle still blocks
    v(0, 1, 16'h0032, 16'h3333, 0, 16'h0000, 0); // W3 accepted
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    v(1, 0, 16'h0030, 16'h0000, 1, 16'h0000, 1); // W1 reached the array
    v(1, 0, 16'h0030, 16'h0000, 1, 16'h0000, 1);
    v(1, 0, 16'h0030, 16'h0000, 1, 16'h0000, 1);
    v(1, 0, 16'h0030, 16'h0000, 0, 16'h1111, 1);
    v(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      re = vecs[i].re; we = vecs[i].we; addr = vecs[i].addr; wrt_data = vecs[i].data;
      @(negedge clk);
      $display("vec %0d re=%b we=%b addr=%h stall=%b rd=%h empty=%b",
               i, re, we, addr, stall, rd_data, wb_empty);
      chk($sformatf("vec%0d_stall", i), {15'd0, stall}, {15'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_empty", i), {15'd0, wb_empty}, {15'd0, vecs[i].exp_empty});
      @(posedge clk); #1;
    end
    re = 0; we = 0;

    // Reset in the middle of a slow read, then reissue the load.
    shadow[10'h020]  = 16'h1234;
    written[10'h020] = 1'b1;
    re = 1; addr = 16'h0020;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdwait_stall", {15'd0, stall}, 16'h0001);
    #2 rst = 1'b1; re = 0;
    #1;
    chk("async_rst_stall", {15'd0, stall}, 16'h0000);
    chk("async_rst_empty", {15'd0, wb_empty}, 16'h0001);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    $display("reset mid-read: stall=%b rd=%h empty=%b", stall, rd_data, wb_empty);
    chk("post_rst_stall", {15'd0, stall}, 16'h0000);
    chk("post_rst_rd", rd_data, 16'h0000);
    chk("post_rst_empty", {15'd0, wb_empty}, 16'h0001);
    @(posedge clk); #1;
    xact(1, 0, 16'h0020, 16'h0000);

    // Randomized traffic on a small address window to provoke hits and misses.
    for (int a = 0; a < 8; a++)
      xact(0, 1, {6'($urandom), 10'(a)}, 16'($urandom));
    for (int t = 0; t < 300; t++) begin
      int kind;
      logic [15:0] ra;
      kind = int'($urandom_range(0, 9));
      ra   = {6'($urandom), 10'($urandom_range(0, 7))};
      if (kind < 4)       xact(0, 1, ra, 16'($urandom));
      else if (kind < 5)  xact(1, 1, ra, 16'($urandom));
      else if (kind < 9)  xact(1, 0, ra, 16'h0000);
      else repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
    end

    // Buffer must eventually drain empty.
    begin
      bit drained;
      drained = 0;
      for (int c = 0; c < 20 && !drained; c++) begin
        @(negedge clk);
        if (wb_empty) drained = 1;
      end
      chk("final_drain", {15'd0, wb_empty}, 16'h0001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_wbuf_ctrl.md
Name: dm_wbuf_ctrl

Overview:
- Data-memory responder that serves the MEM stage's load/store requests on the addr/re/we/wrt_data/rd_data interface.
- Backs a slow single-port word array (LAT cycles per access) with a posted write buffer and store-to-load forwarding.
- Asserts a stall so the pipeline holds while a request cannot complete.

Parameters:
- AW, 10, word-address width; array depth 2**AW; addr[AW-1:0] is used, upper bits are ignored.
- LAT, 2, array access latency in cycles for both reads and drains; must be >=1.
- WB_DEPTH, 2, write-buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  16  word address; held stable by the initiator while stall=1.
- re  in  1  load request.
- we  in  1  store request.
- wrt_data  in  16  store data.
- rd_data  out  16  load data; valid only in the cycle where re=1 and stall=0.
- stall  out  1  combinational; the initiator holds its request while it is high.
- wb_empty  out  1  high when the write buffer holds no entries.

Behaviour:
- Reset: state IDLE, buffer emptied, rd_reg=0, counter=0, stall=0, wb_empty=1. Array contents are not reset. Reset mid-drain or mid-read aborts the access; a lost drain is acceptable.
- re&we together: treated as a store only; re is ignored and rd_data=0.
- Write buffer:
  - FIFO of {addr[AW-1:0], data}.
  - A store is accepted when not full: stall=0, push at the clock edge.
  - When full: stall=1; a pop in the same cycle does not unblock, so the push happens the next cycle.
- Forwarding:
  - A load whose address matches any buffer entry (including the head being drained) is a hit.
  - On a hit, rd_data = data of the youngest matching entry, combinationally; stall=0.
  - A hit is serviced in any state.
- Miss: a load with no match.
  - stall = (re & ~we & ~hit & state!=RD_DONE) | (we & full).
  - rd_data = rd_reg in RD_DONE, forwarded data on a hit, 0 otherwise.
- FSM states: IDLE, DRAIN, RD_WAIT, RD_DONE.
  - IDLE: a pending miss goes to RD_WAIT with cnt=LAT-1. This has priority over draining. Else if the buffer is non-empty, go to DRAIN with cnt=LAT-1. Else stay.
  - DRAIN: cnt decrements each cycle. In the cnt==0 cycle, array[head.addr]<=head.data, pop, go to IDLE. A miss arriving during DRAIN waits (stalled) for completion.
  - RD_WAIT: cnt decrements. At cnt==0, rd_reg<=array[addr], go to RD_DONE.
  - RD_DONE: stall=0, rd_data=rd_reg for exactly one cycle, then IDLE.
- Miss latency from IDLE: stall high for LAT+1 cycles; data is presented in the following cycle.
- Pointers wrap modulo WB_DEPTH; count runs 0..WB_DEPTH.
- A push and a pop in the same cycle leave count unchanged.
- Array reads never see stale data: a miss guarantees no pending entry for that address.

Optional Feature:
- DM_PERF_EN defined: adds output stall_cnt[15:0] and output fwd_cnt[15:0].
  - stall_cnt counts cycles with stall=1.
  - fwd_cnt counts forwarded loads.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset mid-RD_WAIT → next cycle stall=0, rd_data=0, wb_empty=1; a reissued load of 0x0020 completes normally.
- Preload array[0x0020]=0x1234 with LAT=2; issue a load in IDLE → stall=1 for cycles 0-2; cycle 3 has stall=0 and rd_data=0x1234.
- Store 0xBEEF to 0x0010, then a load of 0x0010 the next cycle → stall=0 and rd_data=0xBEEF in the same cycle, while the entry is still draining.
- Stores to 0x0010 (0xAAAA) then 0x0010 (0xBBBB) back-to-back, then a load of 0x0010 → forwards 0xBBBB (youngest match).
- LAT=2, WB_DEPTH=2: stores W1, W2, W3 in cycles 0, 1, 2 → W3 sees stall=1 in cycles 2 and 3 and is accepted in cycle 4. The array holds W1 after cycle 3.
- re=we=1 to 0x0005 with data 0x7777 → treated as a store (stall=0, rd_data=0). A later miss load of 0x0005, after wb_empty=1, returns 0x7777.
